// File: rtl/program_loader_if.sv
// Host byte stream (valid/ready) plus instruction-RAM byte write port.
// Slave is the loader; master is whoever drives the host side and observes the RAM port.
interface program_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_lane;
  logic [7:0]        ram_data;
  logic              ram_we;

  modport master (
    output in_valid, in_data,
    input  in_ready, ram_addr, ram_lane, ram_data, ram_we
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_addr, ram_lane, ram_data, ram_we
  );
endinterface

// File: rtl/program_loader.sv
// Framed program loader: HDR, LEN (word count), 3*LEN payload bytes, checksum byte.
// Writes one RAM byte lane per cycle and holds the CPU in reset until a verified program is resident.
module program_loader #(
  parameter int         ADDR_W   = 6,
  parameter int         TIMEOUT  = 1024,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    sum8 = a + b;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  len_r, len_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [1:0]        lane_r, lane_s;
  logic [7:0]        sum_r, sum_s;
  logic [TMR_W-1:0]  tmr_r, tmr_s;
  logic              we_r, we_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [1:0]        wlane_r, wlane_s;
  logic [7:0]        data_r, data_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              error_r, error_s;
  logic              hold_r, hold_s;
  logic              ready_s;
  logic              accept_s;
  logic              timeout_s;

  assign ready_s   = (state_r == S_HDR) || (state_r == S_LEN) ||
                     (state_r == S_PAYLOAD) || (state_r == S_CHK);
  assign accept_s  = bus.in_valid && ready_s;
  assign timeout_s = (tmr_r == TMR_W'(TIMEOUT - 1));

  // Next-state, datapath and write-strobe decode
  always_comb begin
    state_s = state_r;
    len_s   = len_r;
    cnt_s   = cnt_r;
    lane_s  = lane_r;
    sum_s   = sum_r;
    tmr_s   = tmr_r;
    we_s    = 1'b0;
    addr_s  = addr_r;
    wlane_s = wlane_r;
    data_s  = data_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_s = S_HDR;
          cnt_s   = '0;
          lane_s  = 2'd0;
          sum_s   = 8'd0;
          tmr_s   = '0;
        end else begin
          state_s = state_r;
        end
      end
      S_HDR: begin
        // Non-header bytes are dropped to resynchronise; no timeout here
        if (accept_s && (bus.in_data == HDR_BYTE)) begin
          state_s = S_LEN;
          tmr_s   = '0;
        end else begin
          state_s = S_HDR;
        end
      end
      S_LEN: begin
        if (accept_s) begin
          tmr_s = '0;
          if ((bus.in_data == 8'd0) || ({24'd0, bus.in_data} > 32'(DEPTH))) begin
            state_s = S_ERR;
          end else begin
            len_s   = CNT_W'(bus.in_data);
            sum_s   = bus.in_data;
            state_s = S_PAYLOAD;
          end
        end else if (timeout_s) begin
          state_s = S_ERR;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end
      S_PAYLOAD: begin
        if (accept_s) begin
          tmr_s   = '0;
          sum_s   = sum8(sum_r, bus.in_data);
          we_s    = 1'b1;
          data_s  = bus.in_data;
          addr_s  = cnt_r[ADDR_W-1:0];
          wlane_s = lane_r;
          if (lane_r == 2'd2) begin
            lane_s = 2'd0;
            cnt_s  = cnt_r + CNT_W'(1);
            if ((cnt_r + CNT_W'(1)) == len_r) begin
              state_s = S_CHK;
            end else begin
              state_s = S_PAYLOAD;
            end
          end else begin
            lane_s = lane_r + 2'd1;
          end
        end else if (timeout_s) begin
          state_s = S_ERR;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end
      S_CHK: begin
        if (accept_s) begin
          tmr_s = '0;
          if (sum8(sum_r, bus.in_data) == 8'd0) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ERR;
          end
        end else if (timeout_s) begin
          state_s = S_ERR;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    busy_s  = (state_s == S_HDR) || (state_s == S_LEN) ||
              (state_s == S_PAYLOAD) || (state_s == S_CHK);
    done_s  = (state_s == S_DONE);
    error_s = (state_s == S_ERR);
    hold_s  = (state_s != S_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      len_r   <= '0;
      cnt_r   <= '0;
      lane_r  <= 2'd0;
      sum_r   <= 8'd0;
      tmr_r   <= '0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wlane_r <= 2'd0;
      data_r  <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      hold_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      len_r   <= len_s;
      cnt_r   <= cnt_s;
      lane_r  <= lane_s;
      sum_r   <= sum_s;
      tmr_r   <= tmr_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wlane_r <= wlane_s;
      data_r  <= data_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      error_r <= error_s;
      hold_r  <= hold_s;
    end
  end

  assign bus.in_ready = ready_s;
  assign bus.ram_we   = we_r;
  assign bus.ram_addr = addr_r;
  assign bus.ram_lane = wlane_r;
  assign bus.ram_data = data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign cpu_hold     = hold_r;
endmodule
